// File: rtl/csr_mt.sv
// Multi-thread exception control/status block.
// Holds one exception context per hardware thread: cause code, faulting PC,
// a sticky multi-fault flag and a saturating fault counter. Drives a stall
// vector to the thread scheduler and a combinational read port for debug/OS.
module csr_mt #(
  parameter int          NUM_THR     = 4,
  parameter logic [7:0]  THR_ID_BASE = 8'h01,
  parameter int          PC_W        = 32,
  parameter int          CNT_W       = 8,
  parameter int          TW          = (NUM_THR > 1) ? $clog2(NUM_THR) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic [TW-1:0]      ex_thr,
  input  logic [PC_W-1:0]    ex_pc,
  input  logic               i_cache_seg_fault,
  input  logic               d_cache_seg_fault,
  input  logic               illegal_op,
  input  logic               alu_op_ex,
  input  logic               stack_overflow,
  input  logic               breakpoint,
  input  logic               cpu_error,
  input  logic               clr_ex,
  input  logic [TW-1:0]      clr_thr,
  input  logic [TW-1:0]      rd_thr,
  output logic [5:0]         rd_ex_code,
  output logic [PC_W-1:0]    rd_epc,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic               rd_multi,
  output logic [7:0]         rd_thr_id,
  output logic [NUM_THR-1:0] csr_stall,
  output logic               any_stall
);

  // Cause codes reported through rd_ex_code.
  localparam logic [5:0] C_CLR      = 6'h00;
  localparam logic [5:0] C_ALU      = 6'h01;
  localparam logic [5:0] C_IL_OP    = 6'h05;
  localparam logic [5:0] C_STACK_OV = 6'h0B;
  localparam logic [5:0] C_SEGFAULT = 6'h12;
  localparam logic [5:0] C_CPU_ERR  = 6'h3E;
  localparam logic [5:0] C_BRKPT    = 6'h3F;

  typedef enum logic {ST_OK, ST_FAULT} state_t;

  state_t           r_state [NUM_THR];
  logic [5:0]       r_code  [NUM_THR];
  logic [PC_W-1:0]  r_epc   [NUM_THR];
  logic [CNT_W-1:0] r_cnt   [NUM_THR];
  logic             r_multi [NUM_THR];

  logic [5:0]         w_code;
  logic               w_ex_any;
  logic [NUM_THR-1:0] w_ex_hit;
  logic [NUM_THR-1:0] w_clr_hit;

  // Fixed-priority cause encoder; returns C_CLR when no source is high.
  function automatic logic [5:0] f_cause(input logic cpu, input logic iseg,
                                         input logic dseg, input logic il,
                                         input logic stk, input logic alu,
                                         input logic brk);
    if (cpu)              return C_CPU_ERR;
    else if (iseg || dseg) return C_SEGFAULT;
    else if (il)          return C_IL_OP;
    else if (stk)         return C_STACK_OV;
    else if (alu)         return C_ALU;
    else if (brk)         return C_BRKPT;
    else                  return C_CLR;
  endfunction

  // Decode the exception and clear requests into per-thread hit vectors.
  always_comb begin
    w_code    = f_cause(cpu_error, i_cache_seg_fault, d_cache_seg_fault,
                        illegal_op, stack_overflow, alu_op_ex, breakpoint);
    w_ex_any  = ex_valid && (w_code != C_CLR);
    w_ex_hit  = '0;
    w_clr_hit = '0;
    for (int n = 0; n < NUM_THR; n++) begin
      w_ex_hit[n]  = w_ex_any && (int'(ex_thr) == n);
      w_clr_hit[n] = clr_ex && (int'(clr_thr) == n);
    end
  end

  // Per-thread OK/FAULT FSM with context capture, sticky flag and counter.
  // NOTE: every context array is cleared by reset because the stall vector
  // and read port must show zeros immediately after reset, even mid-fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_THR; n++) begin
        r_state[n] <= ST_OK;
        r_code[n]  <= C_CLR;
        r_epc[n]   <= '0;
        r_cnt[n]   <= '0;
        r_multi[n] <= 1'b0;
      end
    end else begin
      for (int n = 0; n < NUM_THR; n++) begin
        case (r_state[n])
          ST_OK: begin
            // A clear on an idle thread is a no-op; an exception faults it.
            if (w_ex_hit[n]) begin
              r_state[n] <= ST_FAULT;
              r_code[n]  <= w_code;
              r_epc[n]   <= ex_pc;
              r_multi[n] <= 1'b0;
              r_cnt[n]   <= (r_cnt[n] == '1) ? r_cnt[n] : r_cnt[n] + CNT_W'(1);
            end
          end
          ST_FAULT: begin
            if (w_ex_hit[n] && w_clr_hit[n]) begin
              // Clear and new exception together: treat as a fresh fault.
              r_code[n]  <= w_code;
              r_epc[n]   <= ex_pc;
              r_multi[n] <= 1'b0;
              r_cnt[n]   <= (r_cnt[n] == '1) ? r_cnt[n] : r_cnt[n] + CNT_W'(1);
            end else if (w_ex_hit[n]) begin
              // First cause and EPC are held; only flag and count move.
              r_multi[n] <= 1'b1;
              r_cnt[n]   <= (r_cnt[n] == '1) ? r_cnt[n] : r_cnt[n] + CNT_W'(1);
            end else if (w_clr_hit[n]) begin
              r_state[n] <= ST_OK;
              r_code[n]  <= C_CLR;
              r_multi[n] <= 1'b0;
            end
          end
          default: r_state[n] <= ST_OK;
        endcase
      end
    end
  end

  // Stall vector follows the registered FSM state.
  always_comb begin
    csr_stall = '0;
    for (int n = 0; n < NUM_THR; n++) begin
      csr_stall[n] = (r_state[n] == ST_FAULT);
    end
    any_stall = |csr_stall;
  end

  // Combinational read port; out-of-range thread reads as all zeros.
  always_comb begin
    rd_ex_code = '0;
    rd_epc     = '0;
    rd_cnt     = '0;
    rd_multi   = 1'b0;
    rd_thr_id  = '0;
    if (int'(rd_thr) < NUM_THR) begin
      rd_ex_code = r_code[rd_thr];
      rd_epc     = r_epc[rd_thr];
      rd_cnt     = r_cnt[rd_thr];
      rd_multi   = r_multi[rd_thr];
      rd_thr_id  = THR_ID_BASE + 8'(rd_thr);
    end
  end

endmodule

// File: tb/tb_csr_mt.sv
// Directed testbench for csr_mt: a default instance (CNT_W=8) and a second
// instance with CNT_W=2 for counter saturation.
module tb_csr_mt;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [1:0]  ex_thr;
  logic [31:0] ex_pc;
  logic        i_seg, d_seg, il_op, alu_ex, stk_ov, brk, cpu_err;
  logic        clr_ex;
  logic [1:0]  clr_thr;
  logic [1:0]  rd_thr;

  logic [5:0]  rd_ex_code;
  logic [31:0] rd_epc;
  logic [7:0]  rd_cnt;
  logic        rd_multi;
  logic [7:0]  rd_thr_id;
  logic [3:0]  csr_stall;
  logic        any_stall;

  // Stimulus and observation for the CNT_W=2 instance.
  logic        ex_valid2;
  logic [1:0]  ex_thr2;
  logic        brk2;
  logic        clr_ex2;
  logic [1:0]  clr_thr2;
  logic [1:0]  rd_thr2;
  logic [5:0]  rd_ex_code2;
  logic [31:0] rd_epc2;
  logic [1:0]  rd_cnt2;
  logic        rd_multi2;
  logic [7:0]  rd_thr_id2;
  logic [3:0]  csr_stall2;
  logic        any_stall2;

  int n_tests = 0;
  int n_fail  = 0;

  csr_mt #(.NUM_THR(4), .THR_ID_BASE(8'h01), .PC_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_thr(ex_thr), .ex_pc(ex_pc),
    .i_cache_seg_fault(i_seg), .d_cache_seg_fault(d_seg), .illegal_op(il_op),
    .alu_op_ex(alu_ex), .stack_overflow(stk_ov), .breakpoint(brk),
    .cpu_error(cpu_err), .clr_ex(clr_ex), .clr_thr(clr_thr), .rd_thr(rd_thr),
    .rd_ex_code(rd_ex_code), .rd_epc(rd_epc), .rd_cnt(rd_cnt),
    .rd_multi(rd_multi), .rd_thr_id(rd_thr_id), .csr_stall(csr_stall),
    .any_stall(any_stall)
  );

  csr_mt #(.NUM_THR(4), .THR_ID_BASE(8'h01), .PC_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid2), .ex_thr(ex_thr2), .ex_pc(ex_pc),
    .i_cache_seg_fault(1'b0), .d_cache_seg_fault(1'b0), .illegal_op(1'b0),
    .alu_op_ex(1'b0), .stack_overflow(1'b0), .breakpoint(brk2),
    .cpu_error(1'b0), .clr_ex(clr_ex2), .clr_thr(clr_thr2), .rd_thr(rd_thr2),
    .rd_ex_code(rd_ex_code2), .rd_epc(rd_epc2), .rd_cnt(rd_cnt2),
    .rd_multi(rd_multi2), .rd_thr_id(rd_thr_id2), .csr_stall(csr_stall2),
    .any_stall(any_stall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_thr = '0; ex_pc = '0;
    {cpu_err, i_seg, d_seg, il_op, stk_ov, alu_ex, brk} = '0;
    clr_ex = 1'b0; clr_thr = '0;
    ex_valid2 = 1'b0; ex_thr2 = '0; brk2 = 1'b0; clr_ex2 = 1'b0; clr_thr2 = '0;
  endtask

  // srcs = {cpu_error, i_seg, d_seg, illegal, stack, alu, breakpoint}
  task automatic drive_ex(input logic [1:0] thr, input logic [6:0] srcs,
                          input logic [31:0] pc);
    ex_valid = 1'b1; ex_thr = thr; ex_pc = pc;
    {cpu_err, i_seg, d_seg, il_op, stk_ov, alu_ex, brk} = srcs;
  endtask

  task automatic drive_clr(input logic [1:0] thr);
    clr_ex = 1'b1; clr_thr = thr;
  endtask

  initial begin
    idle();
    rd_thr = 2'd0; rd_thr2 = 2'd2;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state.
    check("rst_stall", csr_stall, 4'b0000);
    check("rst_any", any_stall, 1'b0);
    check("rst_code", rd_ex_code, 6'h00);
    check("rst_epc", rd_epc, 32'h0);
    check("rst_cnt", rd_cnt, 8'd0);
    rd_thr = 2'd2; #1;
    check("rst_thr_id2", rd_thr_id, 8'h03);
    check("rst_stall_c2", csr_stall2, 4'b0000);

    // Segfault on thread 1, then clear.
    drive_ex(2'd1, 7'b0100000, 32'h0000_1000); tick(); idle();
    rd_thr = 2'd1; #1;
    check("seg_stall", csr_stall, 4'b0010);
    check("seg_any", any_stall, 1'b1);
    check("seg_code", rd_ex_code, 6'h12);
    check("seg_epc", rd_epc, 32'h0000_1000);
    check("seg_cnt", rd_cnt, 8'd1);
    check("seg_multi", rd_multi, 1'b0);
    check("seg_thr_id", rd_thr_id, 8'h02);
    drive_clr(2'd1); tick(); idle();
    check("clr_stall", csr_stall, 4'b0000);
    check("clr_any", any_stall, 1'b0);
    check("clr_code", rd_ex_code, 6'h00);
    check("clr_cnt", rd_cnt, 8'd1);
    check("clr_epc_kept", rd_epc, 32'h0000_1000);

    // Clear of an idle thread, valid with no source, sources without valid.
    drive_clr(2'd1); tick(); idle();
    check("clr_idle_stall", csr_stall, 4'b0000);
    check("clr_idle_cnt", rd_cnt, 8'd1);
    ex_valid = 1'b1; ex_thr = 2'd1; tick(); idle();
    check("nosrc_stall", csr_stall, 4'b0000);
    ex_thr = 2'd1; {cpu_err, il_op} = 2'b11; tick(); idle();
    check("novalid_stall", csr_stall, 4'b0000);
    check("novalid_cnt", rd_cnt, 8'd1);

    // Priority: cpu_error beats illegal_op and breakpoint on thread 0.
    drive_ex(2'd0, 7'b1001001, 32'h0000_2000); tick(); idle();
    rd_thr = 2'd0; #1;
    check("cpu_stall", csr_stall, 4'b0001);
    check("cpu_code", rd_ex_code, 6'h3E);
    check("cpu_epc", rd_epc, 32'h0000_2000);
    check("cpu_cnt", rd_cnt, 8'd1);

    // Second fault while faulted: cause/EPC held, multi set, cnt 2.
    drive_ex(2'd0, 7'b0000010, 32'h0000_3000); tick(); idle();
    check("multi_code", rd_ex_code, 6'h3E);
    check("multi_epc", rd_epc, 32'h0000_2000);
    check("multi_flag", rd_multi, 1'b1);
    check("multi_cnt", rd_cnt, 8'd2);

    // Segfault beats illegal and stack on thread 2.
    drive_ex(2'd2, 7'b0011100, 32'h0000_4000); tick(); idle();
    rd_thr = 2'd2; #1;
    check("t2_code", rd_ex_code, 6'h12);
    check("t2_stall", csr_stall, 4'b0101);

    // Clear thread 2 while thread 0 takes another exception.
    drive_clr(2'd2); drive_ex(2'd0, 7'b0000010, 32'h0000_5000); tick(); idle();
    check("mix_stall", csr_stall, 4'b0001);
    check("mix_t2_code", rd_ex_code, 6'h00);
    rd_thr = 2'd0; #1;
    check("mix_t0_cnt", rd_cnt, 8'd3);
    check("mix_t0_code", rd_ex_code, 6'h3E);

    // Thread 3: fault, refault (multi), then clear + stack overflow together.
    drive_ex(2'd3, 7'b0000010, 32'h0000_6000); tick(); idle();
    rd_thr = 2'd3; #1;
    check("t3_alu_code", rd_ex_code, 6'h01);
    drive_ex(2'd3, 7'b0000001, 32'h0000_6100); tick(); idle();
    check("t3_multi", rd_multi, 1'b1);
    drive_clr(2'd3); drive_ex(2'd3, 7'b0000100, 32'h0000_7000); tick(); idle();
    check("t3_win_code", rd_ex_code, 6'h0B);
    check("t3_win_epc", rd_epc, 32'h0000_7000);
    check("t3_win_multi", rd_multi, 1'b0);
    check("t3_win_cnt", rd_cnt, 8'd3);
    check("t3_win_stall", csr_stall, 4'b1001);

    // Lower priority levels on thread 2, each followed by a clear.
    rd_thr = 2'd2;
    drive_ex(2'd2, 7'b0001111, 32'h0000_8000); tick(); idle(); #1;
    check("pri_il", rd_ex_code, 6'h05);
    drive_clr(2'd2); tick(); idle();
    drive_ex(2'd2, 7'b0000111, 32'h0000_8004); tick(); idle(); #1;
    check("pri_stk", rd_ex_code, 6'h0B);
    drive_clr(2'd2); tick(); idle();
    drive_ex(2'd2, 7'b0000011, 32'h0000_8008); tick(); idle(); #1;
    check("pri_alu", rd_ex_code, 6'h01);
    drive_clr(2'd2); tick(); idle();
    drive_ex(2'd2, 7'b0000001, 32'h0000_800C); tick(); idle(); #1;
    check("pri_brk", rd_ex_code, 6'h3F);
    check("pri_cnt", rd_cnt, 8'd5);
    drive_clr(2'd2); tick(); idle();

    // CNT_W=2 instance: five breakpoints on thread 2, saturating at 3.
    for (int k = 0; k < 5; k++) begin
      ex_valid2 = 1'b1; ex_thr2 = 2'd2; brk2 = 1'b1; ex_pc = 32'h0000_9000;
      tick(); idle();
      check("c2_code", rd_ex_code2, 6'h3F);
      check("c2_cnt", rd_cnt2, (k < 3) ? 2'(k + 1) : 2'd3);
      clr_ex2 = 1'b1; clr_thr2 = 2'd2; tick(); idle();
    end
    check("c2_sat_cnt", rd_cnt2, 2'd3);
    check("c2_stall_clr", csr_stall2, 4'b0000);

    // Reset while threads 0, 1, 3 are faulted and inputs are active.
    drive_ex(2'd1, 7'b0010000, 32'h0000_A000); tick(); idle();
    check("pre_rst_stall", csr_stall, 4'b1011);
    rst = 1'b1;
    drive_ex(2'd1, 7'b1000000, 32'h0000_B000); drive_clr(2'd0);
    tick(); idle();
    rst = 1'b0;
    check("mrst_stall", csr_stall, 4'b0000);
    check("mrst_any", any_stall, 1'b0);
    for (int t = 0; t < 4; t++) begin
      rd_thr = 2'(t); #1;
      check("mrst_code", rd_ex_code, 6'h00);
      check("mrst_epc", rd_epc, 32'h0);
      check("mrst_cnt", rd_cnt, 8'd0);
      check("mrst_multi", rd_multi, 1'b0);
      check("mrst_thr_id", rd_thr_id, 8'(t + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
